// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// mac_pkg : XGMII control characters, CRC-32 constants/helpers, rx state type
// Rev 1.0
// ============================================================================
package mac_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] ETH_PRE     = 8'h55;
  localparam logic [7:0] ETH_SFD     = 8'hD5;

  // Lane 0 is the low byte, so the start word reads 555555FB on the bus.
  localparam logic [31:0] START_WORD = {ETH_PRE, ETH_PRE, ETH_PRE, XGMII_START};
  localparam logic [31:0] SFD_WORD   = {ETH_SFD, ETH_PRE, ETH_PRE, ETH_PRE};
  localparam logic [31:0] IDLE_WORD  = {4{XGMII_IDLE}};

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

  localparam int MIN_FRAME_BYTES_DEFAULT = 64;
  localparam int MAX_FRAME_BYTES_DEFAULT = 1518;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_PREAMBLE = 3'd1,
    RX_DATA     = 3'd2,
    RX_FLUSH    = 3'd3,
    RX_DROP     = 3'd4
  } rx_state_t;

  // Table 'depth' entry: register contribution of byte idx followed by depth zero bytes.
  function automatic logic [31:0] crc32_table_entry(input logic [7:0] idx, input int depth);
    logic [31:0] c;
    c = {24'h0, idx};
    for (int b = 0; b < 32; b++) begin
      if (b < 8 * (depth + 1)) begin
        c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_crc32.sv
`default_nettype none
// ============================================================================
// rx_crc32 : slicing-by-4 reflected CRC-32, 1..4 bytes per step (0 = 4 bytes)
// Rev 1.0
// ============================================================================
module rx_crc32
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] crc,
  output logic [31:0] crc_next
);

  logic [31:0] table0 [256];
  logic [31:0] table1 [256];
  logic [31:0] table2 [256];
  logic [31:0] table3 [256];
  logic [31:0] mix;

  for (genvar i = 0; i < 256; i++) begin : g_table
    assign table0[i] = crc32_table_entry(8'(i), 0);
    assign table1[i] = crc32_table_entry(8'(i), 1);
    assign table2[i] = crc32_table_entry(8'(i), 2);
    assign table3[i] = crc32_table_entry(8'(i), 3);
  end

  assign mix = crc ^ data;

  always_comb begin
    crc_next = '0;
    case (nbytes)
      3'd1:    crc_next = (crc >> 8)  ^ table0[mix[7:0]];
      3'd2:    crc_next = (crc >> 16) ^ table1[mix[7:0]] ^ table0[mix[15:8]];
      3'd3:    crc_next = (crc >> 24) ^ table2[mix[7:0]] ^ table1[mix[15:8]]
                                      ^ table0[mix[23:16]];
      default: crc_next = table3[mix[7:0]] ^ table2[mix[15:8]]
                        ^ table1[mix[23:16]] ^ table0[mix[31:24]];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_mac.sv
`default_nettype none
// ============================================================================
// rx_mac : XGMII-32 receive MAC, strips preamble/SFD/FCS, AXI-Stream output
// Rev 1.0
// ============================================================================
module rx_mac
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int MIN_FRAME_BYTES = MIN_FRAME_BYTES_DEFAULT,
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] i_xgmii_ctrl,
  input  logic                  i_xgmii_valid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CTRL_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  o_frame_good,
  output logic                  o_frame_bad
);

  localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_BYTES);
  localparam logic [16:0] MAX_LEN = 17'(MAX_FRAME_BYTES);

  rx_state_t   state;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        d1_vld;
  logic        d2_vld;
  logic [15:0] byte_cnt;
  logic        flush_bad;
  logic [3:0]  flush_keep;

  logic [31:0] rxd;
  logic [3:0]  ctrl;
  logic        is_start;
  logic        is_sfd;
  logic        all_data;
  logic        all_idle;
  logic        is_term;
  logic        any_term;
  logic [1:0]  term_lane;
  logic [3:0]  term_keep;
  logic [7:0]  term_byte;

  logic [31:0] crc;
  logic [31:0] crc_next;
  logic        crc_init;
  logic        crc_en;
  logic [2:0]  crc_nbytes;
  logic [16:0] frame_len;
  logic        len_bad;
  logic        crc_bad;
  logic        frame_bad;

  assign rxd  = i_xgmii_rxd;
  assign ctrl = i_xgmii_ctrl;

  assign is_start = (ctrl == 4'b0001) && (rxd == START_WORD);
  assign is_sfd   = (ctrl == 4'b0000) && (rxd == SFD_WORD);
  assign all_data = (ctrl == 4'b0000);
  assign all_idle = (ctrl == 4'b1111) && (rxd == IDLE_WORD);

  // The lowest control lane decides: a TERM there ends the frame, anything else is an error.
  always_comb begin
    term_lane = 2'd0;
    term_keep = 4'b0000;
    casez (ctrl)
      4'b???1: begin term_lane = 2'd0; term_keep = 4'b0000; end
      4'b??10: begin term_lane = 2'd1; term_keep = 4'b0001; end
      4'b?100: begin term_lane = 2'd2; term_keep = 4'b0011; end
      4'b1000: begin term_lane = 2'd3; term_keep = 4'b0111; end
      default: begin term_lane = 2'd0; term_keep = 4'b0000; end
    endcase
  end

  assign term_byte = rxd[{term_lane, 3'b000} +: 8];
  assign is_term   = (ctrl != 4'b0000) && (term_byte == XGMII_TERM);

  always_comb begin
    any_term = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ctrl[k] && (rxd[8*k +: 8] == XGMII_TERM)) begin
        any_term = 1'b1;
      end
    end
  end

  assign crc_init   = (state == RX_PREAMBLE);
  assign crc_en     = (state == RX_DATA) && i_xgmii_valid && all_data;
  assign crc_nbytes = all_data ? 3'd4 : {1'b0, term_lane};

  rx_crc32 u_crc (
    .clk      (i_clk),
    .rst      (i_reset),
    .init     (crc_init),
    .en       (crc_en),
    .data     (rxd),
    .nbytes   (crc_nbytes),
    .crc      (crc),
    .crc_next (crc_next)
  );

  // A lane-0 TERM leaves the register already holding the full DA..FCS residue.
  assign frame_len = {1'b0, byte_cnt} + {15'd0, term_lane};
  assign len_bad   = (frame_len < MIN_LEN) || (frame_len > MAX_LEN);
  assign crc_bad   = ((term_lane == 2'd0) ? crc : crc_next) != CRC32_RESIDUE;
  assign frame_bad = len_bad || crc_bad;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= RX_IDLE;
      d1            <= '0;
      d2            <= '0;
      d1_vld        <= 1'b0;
      d2_vld        <= 1'b0;
      byte_cnt      <= '0;
      flush_bad     <= 1'b0;
      flush_keep    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      o_frame_good  <= 1'b0;
      o_frame_bad   <= 1'b0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tkeep  <= '0;
      o_frame_good  <= 1'b0;
      o_frame_bad   <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (i_xgmii_valid && is_start) begin
            state <= RX_PREAMBLE;
          end
        end
        RX_PREAMBLE: begin
          if (i_xgmii_valid) begin
            if (is_sfd) begin
              state    <= RX_DATA;
              d1_vld   <= 1'b0;
              d2_vld   <= 1'b0;
              byte_cnt <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (i_xgmii_valid) begin
            if (all_data) begin
              if (d2_vld) begin
                m_axis_tdata  <= d2;
                m_axis_tkeep  <= 4'hF;
                m_axis_tvalid <= 1'b1;
              end
              d2       <= d1;
              d2_vld   <= d1_vld;
              d1       <= rxd;
              d1_vld   <= 1'b1;
              byte_cnt <= (byte_cnt > 16'hFFFB) ? 16'hFFFF : byte_cnt + 16'd4;
            end else if (is_term) begin
              if (!d2_vld) begin
                state <= RX_IDLE;
              end else begin
                m_axis_tdata  <= d2;
                m_axis_tkeep  <= 4'hF;
                m_axis_tvalid <= 1'b1;
                if (term_lane == 2'd0) begin
                  m_axis_tlast <= 1'b1;
                  m_axis_tuser <= frame_bad;
                  o_frame_good <= !frame_bad;
                  o_frame_bad  <= frame_bad;
                  state        <= RX_IDLE;
                end else begin
                  flush_bad  <= frame_bad;
                  flush_keep <= term_keep;
                  state      <= RX_FLUSH;
                end
              end
            end else begin
              if (d2_vld) begin
                m_axis_tdata  <= d2;
                m_axis_tkeep  <= 4'hF;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b1;
                m_axis_tuser  <= 1'b1;
                o_frame_bad   <= 1'b1;
              end
              state <= RX_DROP;
            end
          end
        end
        RX_FLUSH: begin
          m_axis_tdata  <= d1;
          m_axis_tkeep  <= flush_keep;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= 1'b1;
          m_axis_tuser  <= flush_bad;
          o_frame_good  <= !flush_bad;
          o_frame_bad   <= flush_bad;
          state         <= (i_xgmii_valid && is_start) ? RX_PREAMBLE : RX_IDLE;
        end
        RX_DROP: begin
          if (i_xgmii_valid && (any_term || all_idle)) begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_mac.sv
`default_nettype none
// tb_rx_mac : random frames built at byte level, expected beats derived from the receive rules.
module tb_rx_mac;

  localparam int M_NORMAL = 0;
  localparam int M_ERR    = 1;
  localparam int M_RESET  = 2;
  localparam int M_SFD    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rxd;
  logic [3:0]  ctrl;
  logic        xvalid;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic        fgood;
  logic        fbad;

  always #5 clk = ~clk;

  rx_mac dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_xgmii_rxd   (rxd),
    .i_xgmii_ctrl  (ctrl),
    .i_xgmii_valid (xvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .o_frame_good  (fgood),
    .o_frame_bad   (fbad)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
    logic        good;
    logic        bad;
  } beat_t;

  beat_t        cap[$];
  beat_t        exp_q[$];
  byte unsigned frame[$];
  int           tests = 0;
  int           fails = 0;
  int           stray = 0;
  bit           pause_mode = 1'b0;

  always @(negedge clk) begin
    if (tvalid === 1'b1) cap.push_back({tdata, tkeep, tlast, tuser, fgood, fbad});
    if ((fgood === 1'b1 || fbad === 1'b1) && !(tvalid === 1'b1 && tlast === 1'b1)) stray++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_bytes(input int count);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < count; i++) begin
      c = c ^ {24'h0, frame[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic make_frame(input int plen, input bit flip);
    logic [31:0] fcs;
    frame.delete();
    for (int i = 0; i < plen; i++) frame.push_back(8'($urandom_range(0, 255)));
    fcs = ~crc_bytes(plen);
    for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
    if (flip) frame[plen+1] = frame[plen+1] ^ 8'h10;
  endtask

  // Expected AXI beats for the current frame, from payload bytes and the accept/reject rules.
  task automatic add_expected(input int mode, input int cut);
    int    len;
    int    plen;
    int    nb;
    bit    bad;
    beat_t b;
    len  = frame.size();
    plen = len - 4;
    if (mode == M_SFD) return;
    if (mode == M_NORMAL) begin
      if (len / 4 < 2) return;
      bad = (len < 64) || (len > 1518) || (crc_bytes(len) != 32'hDEBB_20E3);
      nb  = (plen + 3) / 4;
    end else begin
      bad = 1'b1;
      nb  = (mode == M_ERR) ? cut - 1 : cut - 2;
      plen = 4 * nb;
    end
    for (int w = 0; w < nb; w++) begin
      b = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * w + j < plen) begin
          b.data[8*j +: 8] = frame[4*w+j];
          b.keep[j] = 1'b1;
        end
      end
      b.last = (w == nb - 1) && (mode != M_RESET);
      b.user = b.last && bad;
      b.good = b.last && !bad;
      b.bad  = b.last && bad;
      exp_q.push_back(b);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] c);
    if (pause_mode) begin
      xvalid = 1'b0;
      rxd    = $urandom;
      ctrl   = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    rxd    = d;
    ctrl   = c;
    xvalid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int mode, input int cut, input int ipg);
    int          len;
    int          nw;
    int          k;
    logic [31:0] w;
    logic [3:0]  c;
    len = frame.size();
    nw  = len / 4;
    k   = len % 4;
    send(32'h5555_55FB, 4'b0001);
    send((mode == M_SFD) ? 32'hD455_5555 : 32'hD555_5555, 4'b0000);
    for (int i = 0; i < nw; i++) begin
      if (mode == M_RESET && i == cut) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_frame_outputs", 64'({tdata, tkeep, tvalid, tlast, tuser, fgood, fbad}), 64'd0);
        rst = 1'b0;
      end
      for (int j = 0; j < 4; j++) w[8*j +: 8] = frame[4*i+j];
      c = 4'b0000;
      if (mode == M_ERR && i == cut) begin
        w[23:16] = 8'hFE;
        c        = 4'b0100;
      end
      send(w, c);
    end
    w = 32'h0707_0707;
    c = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      if (j < k) begin
        w[8*j +: 8] = frame[4*nw+j];
        c[j] = 1'b0;
      end
    end
    w[8*k +: 8] = 8'hFD;
    send(w, c);
    repeat (ipg) send(32'h0707_0707, 4'b1111);
  endtask

  task automatic check_frames(input string tag);
    beat_t       o;
    beat_t       e;
    logic [31:0] m;
    check({tag, "_beat_count"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      o = cap[i];
      e = exp_q[i];
      for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{e.keep[j]}};
      o.data = o.data & m;
      check($sformatf("%s_beat%0d", tag, i), 64'(o), 64'(e));
    end
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    int plen;
    rst    = 1'b1;
    rxd    = 32'h0707_0707;
    ctrl   = 4'hF;
    xvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({tdata, tkeep, tvalid, tlast, tuser, fgood, fbad}), 64'd0);
    rst = 1'b0;
    repeat (2) send(32'h0707_0707, 4'b1111);
    cap.delete();

    // Payloads of 60..63 bytes exercise TERM in lanes 0..3.
    for (int p = 60; p <= 63; p++) begin
      make_frame(p, 1'b0);
      add_expected(M_NORMAL, 0);
      send_frame(M_NORMAL, 0, 4);
      check_frames($sformatf("len%0d", p));
    end

    make_frame(60, 1'b1);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 4);
    check_frames("bad_fcs");

    // ERROR in the tenth payload word, then a clean frame to show recovery.
    make_frame(100, 1'b0);
    add_expected(M_ERR, 9);
    send_frame(M_ERR, 9, 2);
    make_frame(62, 1'b0);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 4);
    check_frames("error_char");

    make_frame(60, 1'b0);
    send_frame(M_SFD, 0, 2);
    make_frame(61, 1'b0);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 4);
    check_frames("bad_sfd");

    make_frame(1596, 1'b0);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 4);
    check_frames("oversize");

    pause_mode = 1'b1;
    make_frame(60, 1'b0);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 3);
    make_frame(63, 1'b0);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 3);
    check_frames("paused");
    pause_mode = 1'b0;

    make_frame(80, 1'b0);
    add_expected(M_RESET, 6);
    send_frame(M_RESET, 6, 2);
    make_frame(64, 1'b0);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 4);
    check_frames("reset_mid");

    // START in the word right after a lane-1 TERM is taken while FLUSH drains.
    make_frame(61, 1'b0);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 0);
    make_frame(60, 1'b0);
    add_expected(M_NORMAL, 0);
    send_frame(M_NORMAL, 0, 4);
    check_frames("back_to_back");

    for (int r = 0; r < 10; r++) begin
      plen = $urandom_range(0, 130);
      pause_mode = 1'($urandom_range(0, 1));
      make_frame(plen, $urandom_range(0, 3) == 0);
      add_expected(M_NORMAL, 0);
      send_frame(M_NORMAL, 0, $urandom_range(1, 3));
      repeat (3) send(32'h0707_0707, 4'b1111);
      check_frames($sformatf("random%0d_len%0d", r, plen + 4));
    end
    pause_mode = 1'b0;

    check("stray_good_bad_pulses", 64'(stray), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
